// File: rtl/regfile_pkg.sv
// Shared constants for the forwarding register file: default geometry,
// the depth helper and the hard-wired zero register index.
package regfile_pkg;

  localparam int unsigned RF_DEF_DATA_W = 32;
  localparam int unsigned RF_DEF_ADDR_W = 5;
  localparam int unsigned RF_DEF_NUM_RD = 2;
  localparam int unsigned RF_DEF_NUM_FWD = 3;

  // Register 0 always reads as zero and is never written.
  localparam int unsigned RF_REG_ZERO = 0;

  // Number of architectural registers for a given address width.
  function automatic int unsigned rf_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port operand select: zero register, then bypass channels
// (lowest index = youngest stage wins), then same-cycle commit, then storage.
module rf_bypass_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DEF_DATA_W,
  parameter int unsigned ADDR_W  = RF_DEF_ADDR_W,
  parameter int unsigned NUM_FWD = RF_DEF_NUM_FWD
) (
  input  logic [ADDR_W-1:0]         rd_addr_i,
  input  logic [DATA_W-1:0]         reg_data_i,
  input  logic                      we_i,
  input  logic [ADDR_W-1:0]         w_addr_i,
  input  logic [DATA_W-1:0]         w_data_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
  output logic [DATA_W-1:0]         rd_data_o
);

  // Priority select of the read operand.
  always_comb begin
    logic found;
    found     = 1'b0;
    rd_data_o = reg_data_i;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_we_i[i] && (fwd_addr_i[i*ADDR_W +: ADDR_W] == rd_addr_i)) begin
        rd_data_o = fwd_data_i[i*DATA_W +: DATA_W];
        found     = 1'b1;
      end
    end
    if (!found && we_i && (w_addr_i == rd_addr_i)) begin
      rd_data_o = w_data_i;
    end
    if (rd_addr_i == ADDR_W'(RF_REG_ZERO)) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/fwd_reg_file.sv
// Register file with bypass network, load-pending scoreboard and hazard
// detection. Optional link-register write port when FWD_REG_FILE_LINK_EN
// is defined.
module fwd_reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DEF_DATA_W,
  parameter int unsigned ADDR_W  = RF_DEF_ADDR_W,
  parameter int unsigned NUM_RD  = RF_DEF_NUM_RD,
  parameter int unsigned NUM_FWD = RF_DEF_NUM_FWD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         w_addr,
  input  logic [DATA_W-1:0]         w_data,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      pend_set,
  input  logic [ADDR_W-1:0]         pend_addr,
  output logic [NUM_RD-1:0]         hazard,
  output logic [ADDR_W:0]           pend_cnt
`ifdef FWD_REG_FILE_LINK_EN
  ,
  input  logic                      lr_we,
  input  logic [DATA_W-1:0]         lr_data
`endif
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              commit;

  assign commit = we && (w_addr != ZERO_ADDR);

  // Next-state for storage, pending bits and their population count.
  // The count is recomputed from the next pending vector so simultaneous
  // set/clear (and link clears) always net out correctly.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
`ifdef FWD_REG_FILE_LINK_EN
    if (lr_we) begin
      regs_d[DEPTH-1] = lr_data;
      pend_d[DEPTH-1] = 1'b0;
    end
`endif
    if (commit) begin
      regs_d[w_addr] = w_data;
      pend_d[w_addr] = 1'b0;
    end
    if (pend_set && (pend_addr != ZERO_ADDR)) begin
      pend_d[pend_addr] = 1'b1;
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    rf_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD)
    ) u_mux (
      .rd_addr_i  (ra),
      .reg_data_i (regs_q[ra]),
      .we_i       (we),
      .w_addr_i   (w_addr),
      .w_data_i   (w_data),
      .fwd_we_i   (fwd_we),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .rd_data_o  (rd_data[p*DATA_W +: DATA_W])
    );

    assign hazard[p] = rd_en[p] && (ra != ZERO_ADDR) && pend_q[ra]
                       && !(we && (w_addr == ra));
  end

endmodule

// File: doc/fwd_reg_file.md
FWD_REG_FILE -- requirements
Module: fwd_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports.
REQ-004 SHALL have parameter NUM_FWD, default 3: number of bypass channels; index 0 is the youngest stage (EX).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port we, input, 1: commit write enable.
REQ-008 SHALL have port w_addr, input, ADDR_W: commit write address.
REQ-009 SHALL have port w_data, input, DATA_W: commit write data.
REQ-010 SHALL have port rd_en, input, NUM_RD: per-port read valid, used for hazard qualification only.
REQ-011 SHALL have port rd_addr, input, NUM_RD*ADDR_W: packed read addresses, port p in bits [p*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rd_data, output, NUM_RD*DATA_W: packed read data.
REQ-013 SHALL have ports fwd_we, fwd_addr and fwd_data, inputs, widths NUM_FWD, NUM_FWD*ADDR_W and NUM_FWD*DATA_W: bypass channels.
REQ-014 SHALL have ports pend_set and pend_addr, inputs, widths 1 and ADDR_W: mark a destination as awaiting a load result.
REQ-015 SHALL have port hazard, output, NUM_RD: per-port load-use hazard.
REQ-016 SHALL have port pend_cnt, output, ADDR_W+1: number of pending registers.

Function
REQ-017 SHALL produce rd_data combinationally per port using this priority: address 0 gives 0; otherwise the lowest-index fwd channel with fwd_we=1 and a matching address; otherwise the same-cycle commit write (we=1 and matching w_addr); otherwise the stored value.
REQ-018 SHALL never let a bypass or commit targeting address 0 affect any read.
REQ-019 SHALL write w_data to regs[w_addr] at the clock edge when we=1 and w_addr is not 0.
REQ-020 SHALL keep one pending bit per register, set at the edge when pend_set=1 and pend_addr is not 0.
REQ-021 SHALL clear a register's pending bit at the edge of a commit write (we=1) to that address.
REQ-022 SHALL let set win when a set and a clear target the same address in the same cycle, so the bit stays 1.
REQ-023 SHALL ignore pend_set on a register that is already pending, with no state change and no count change.
REQ-024 SHALL assert hazard[p] = rd_en[p] AND pending[rd_addr[p]] AND NOT (we=1 with w_addr equal to rd_addr[p]); hazard is never asserted for address 0.
REQ-025 SHALL keep pend_cnt equal to the population count of the pending bits, updated in the same edge as the bits (+1, -1 or net 0); it never wraps.
REQ-026 SHALL impose zero cycles of read latency, one cycle of write latency and one cycle of pending-bit latency.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all registers, pending bits and pend_cnt.
REQ-028 SHALL, during reset, drive hazard to 0 and have rd_data reflect only the bypass inputs, or 0 otherwise.
REQ-029 SHALL lose any state update scheduled for the edge at which reset asserts mid-operation; the first update occurs at the first rising edge after rst returns to 1.

Configuration
REQ-030 SHALL, when FWD_REG_FILE_LINK_EN is defined, add ports lr_we (1 bit) and lr_data (DATA_W) that write the top register (2**ADDR_W - 1) at the edge.
REQ-031 SHALL, with FWD_REG_FILE_LINK_EN defined, give the main commit priority when both write the top register in the same cycle, and have lr_we also clear that register's pending bit.
REQ-032 SHALL, with FWD_REG_FILE_LINK_EN defined, forward the link write only after it is committed (no same-cycle bypass of lr_data).
REQ-033 SHALL, without FWD_REG_FILE_LINK_EN, have no link ports and treat the top register as an ordinary register.

Structure
REQ-034 SHALL place the default widths, the depth function and the register-0 constant in the shared package regfile_pkg.
REQ-035 SHALL implement the per-port priority mux as the sub-module rf_bypass_mux, instantiated NUM_RD times.

Verification
REQ-036 SHALL check: write regs[5]=0x1234 (we=1), then the next cycle read port 0 at address 5 -> 0x1234.
REQ-037 SHALL check: fwd channels 0 and 2 both target address 7 with 0xA and 0xC -> rd_data = 0xA; deassert fwd_we[0] -> 0xC.
REQ-038 SHALL check: we=1, w_addr=0, w_data=0xFFFF_FFFF, plus fwd to address 0 -> reads of address 0 return 0.
REQ-039 SHALL check: pend_set on address 9, then rd_en=1 at address 9 -> hazard=1 and pend_cnt=1; commit to 9 -> hazard=0 in the same cycle and pend_cnt=0 after the edge.
REQ-040 SHALL check: pend_set to 4 and commit to 4 in the same cycle -> pending[4]=1 and pend_cnt unchanged at +1.
REQ-041 SHALL check: pend 3 registers, then pull rst low mid-cycle -> registers, pend_cnt and hazard are 0 immediately, before any clock edge.
